sample_mixer: RTL and testbench



---
 rtl/mixer_pkg.sv | 36 +++
 rtl/sample_mixer_if.sv | 38 +++
 rtl/pblrc_edge_detect.sv | 32 +++
 rtl/sample_mixer.sv | 196 +++++++++++++++++++
 tb/tb_sample_mixer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mixer_pkg.sv
// ============================================================================
// Module   : mixer_pkg
// Purpose  : Shared types, constants and the 16-bit saturation helper used by
//            the sample mixer and its testbench.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mixer_pkg;

  typedef shortint    sample_t;
  typedef logic [7:0] gain_t;

  localparam int UNITY_GAIN     = 128;
  localparam int GAIN_SHIFT_DEF = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } mixer_state_t;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic sample_t sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return sample_t'(16'sh7fff);
    end else if (v < -64'sd32768) begin
      return sample_t'(16'sh8000);
    end else begin
      return sample_t'(v[15:0]);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_mixer_if.sv
// ============================================================================
// Module   : sample_mixer_if
// Purpose  : Bundles the per-voice sample inputs, frame clock and mixed
//            outputs of the sample mixer. The mixer uses the slave modport;
//            the voice/frame side uses the master modport.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sample_mixer_if #(
  parameter int N_CH      = 4,
  parameter int GAIN_BITS = 8
);

  logic                        pblrc;
  logic [N_CH*16-1:0]          ch_in;
  logic [N_CH*GAIN_BITS-1:0]   ch_gain;
  logic [N_CH-1:0]             ch_mute;
  logic                        clear_overrun;
  logic [15:0]                 mix_out;
  logic                        mix_valid;
  logic                        clip;
  logic                        overrun;
  logic [14:0]                 peak_out;

  modport master (
    output pblrc, ch_in, ch_gain, ch_mute, clear_overrun,
    input  mix_out, mix_valid, clip, overrun, peak_out
  );

  modport slave (
    input  pblrc, ch_in, ch_gain, ch_mute, clear_overrun,
    output mix_out, mix_valid, clip, overrun, peak_out
  );

endinterface

`default_nettype wire

// File: rtl/pblrc_edge_detect.sv
// ============================================================================
// Module   : pblrc_edge_detect
// Purpose  : Rising-edge detector for the mclk-synchronous playback LR clock.
//            Produces a combinational one-cycle rise flag for frame-domain
//            stages.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pblrc_edge_detect (
  input  logic mclk,
  input  logic rst,
  input  logic pblrc,
  output logic rise
);

  logic pblrc_q;

  // Delay pblrc by one mclk to compare against the live level.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pblrc_q <= 1'b0;
    end else begin
      pblrc_q <= pblrc;
    end
  end

  assign rise = pblrc & ~pblrc_q;

endmodule

`default_nettype wire

// File: rtl/sample_mixer.sv
// ============================================================================
// Module   : sample_mixer
// Purpose  : Once per audio frame, snapshots all voice channels, accumulates
//            the gain-weighted samples one channel per mclk with a single
//            multiplier, shifts, saturates to 16 bits and pulses mix_valid.
//            Optional peak-hold meter enabled by defining MIXER_PEAK_HOLD_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_mixer
  import mixer_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int GAIN_BITS  = 8,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF
) (
  input  logic            mclk,
  input  logic            rst,
  sample_mixer_if.slave   bus
);

  localparam int PROD_W = 17 + GAIN_BITS;
  localparam int ACC_W  = PROD_W + $clog2(N_CH);
  localparam int IDX_W  = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  logic                        rise;
  mixer_state_t                r_state;
  mixer_state_t                w_next;
  logic                        w_snap;
  logic                        w_acc_en;
  logic                        w_sat;

  logic [N_CH*16-1:0]          r_ch_snap;
  logic [N_CH*GAIN_BITS-1:0]   r_gain_snap;
  logic [N_CH-1:0]             r_mute_snap;
  logic signed [ACC_W-1:0]     r_acc;
  logic [IDX_W-1:0]            r_idx;

  logic signed [15:0]          r_mix_out;
  logic                        r_mix_valid;
  logic                        r_clip;
  logic                        r_overrun;

  logic signed [15:0]          w_sample;
  logic [GAIN_BITS-1:0]        w_gain;
  logic                        w_muted;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_shifted;
  logic signed [63:0]          w_sat_in;
  logic                        w_clip;

  pblrc_edge_detect u_edge (
    .mclk  (mclk),
    .rst   (rst),
    .pblrc (bus.pblrc),
    .rise  (rise)
  );

  // State register for the snapshot / accumulate / saturate sequence.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next   = r_state;
    w_snap   = 1'b0;
    w_acc_en = 1'b0;
    w_sat    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rise) begin
          w_snap = 1'b1;
          w_next = ACCUM;
        end
      end
      ACCUM: begin
        w_acc_en = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next = SAT;
        end
      end
      SAT: begin
        w_sat  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_sample = r_ch_snap[16*int'(r_idx) +: 16];
  assign w_gain   = r_gain_snap[GAIN_BITS*int'(r_idx) +: GAIN_BITS];
  assign w_muted  = r_mute_snap[r_idx];

  // Single shared multiplier; the gain is zero-extended so it multiplies as unsigned.
  always_comb begin
    w_prod = '0;
    if (!w_muted) begin
      w_prod = $signed({{(PROD_W-16){w_sample[15]}}, w_sample}) *
               $signed({{(PROD_W-GAIN_BITS){1'b0}}, w_gain});
    end
  end

  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_shifted  = r_acc >>> GAIN_SHIFT;
  assign w_sat_in   = {{(64-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};
  assign w_clip     = (w_sat_in > 64'sd32767) || (w_sat_in < -64'sd32768);

  // Snapshot, accumulate and output registers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_ch_snap   <= '0;
      r_gain_snap <= '0;
      r_mute_snap <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_clip      <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      if (w_snap) begin
        r_ch_snap   <= bus.ch_in;
        r_gain_snap <= bus.ch_gain;
        r_mute_snap <= bus.ch_mute;
        r_acc       <= '0;
        r_idx       <= '0;
      end
      if (w_acc_en) begin
        r_acc <= r_acc + w_prod_ext;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_sat) begin
        r_mix_out   <= sat16(w_sat_in);
        r_clip      <= w_clip;
        r_mix_valid <= 1'b1;
      end
    end
  end

  // Sticky overrun: a frame start while busy sets it, and setting beats clearing.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (rise && (r_state != IDLE)) begin
      r_overrun <= 1'b1;
    end else if (bus.clear_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.mix_out   = r_mix_out;
  assign bus.mix_valid = r_mix_valid;
  assign bus.clip      = r_clip;
  assign bus.overrun   = r_overrun;

`ifdef MIXER_PEAK_HOLD_EN
  logic [14:0] r_peak;
  logic [14:0] w_mag;

  // Magnitude of the current mix, with -32768 folded onto 32767.
  always_comb begin
    w_mag = r_mix_out[14:0];
    if (r_mix_out == 16'sh8000) begin
      w_mag = 15'h7fff;
    end else if (r_mix_out[15]) begin
      w_mag = 15'(-r_mix_out);
    end
  end

  // Peak-hold meter, cleared together with the overrun flag.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (bus.clear_overrun) begin
      r_peak <= '0;
    end else if (r_mix_valid && (w_mag > r_peak)) begin
      r_peak <= w_mag;
    end
  end

  assign bus.peak_out = r_peak;
`else
  assign bus.peak_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_mixer.sv
// ============================================================================
// Module   : tb_sample_mixer
// Purpose  : Self-checking bench for sample_mixer: directed frames from the
//            test plan plus randomized frames compared against an arithmetic
//            reference model of the mix.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sample_mixer;
  import mixer_pkg::*;

  localparam int N_CH       = 4;
  localparam int GAIN_BITS  = 8;
  localparam int GAIN_SHIFT = 7;

  logic mclk = 1'b0;
  logic rst  = 1'b1;

  always #5 mclk = ~mclk;

  sample_mixer_if #(.N_CH(N_CH), .GAIN_BITS(GAIN_BITS)) bus ();

  sample_mixer #(
    .N_CH       (N_CH),
    .GAIN_BITS  (GAIN_BITS),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int st_ch   [N_CH];
  int st_gain [N_CH];
  logic [N_CH-1:0] st_mute;
  int peak_m = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Reference: weighted sum, floor division by 2^GAIN_SHIFT, clamp to 16 bits.
  function automatic void model(output int res, output int clp);
    longint sum;
    longint s;
    longint d;
    sum = 0;
    d   = longint'(1) << GAIN_SHIFT;
    for (int k = 0; k < N_CH; k++) begin
      if (!st_mute[k]) sum += longint'(st_ch[k]) * longint'(st_gain[k]);
    end
    if (sum >= 0) s = sum / d;
    else          s = -((-sum + d - 1) / d);
    if (s > 32767) begin
      res = 32767; clp = 1;
    end else if (s < -32768) begin
      res = -32768; clp = 1;
    end else begin
      res = int'(s); clp = 0;
    end
  endfunction

  task automatic update_peak(input int res);
`ifdef MIXER_PEAK_HOLD_EN
    int a;
    a = (res < 0) ? -res : res;
    if (a > 32767) a = 32767;
    if (a > peak_m) peak_m = a;
`else
    if (res == 0) peak_m = 0;
`endif
  endtask

  task automatic set_stim(input int c0, input int c1, input int c2, input int c3,
                          input int g0, input int g1, input int g2, input int g3,
                          input logic [N_CH-1:0] m);
    st_ch[0] = c0; st_ch[1] = c1; st_ch[2] = c2; st_ch[3] = c3;
    st_gain[0] = g0; st_gain[1] = g1; st_gain[2] = g2; st_gain[3] = g3;
    st_mute = m;
  endtask

  task automatic apply();
    for (int k = 0; k < N_CH; k++) begin
      bus.ch_in[16*k +: 16]               = st_ch[k][15:0];
      bus.ch_gain[GAIN_BITS*k +: GAIN_BITS] = st_gain[k][GAIN_BITS-1:0];
    end
    bus.ch_mute = st_mute;
  endtask

  task automatic scramble();
    for (int k = 0; k < N_CH; k++) begin
      bus.ch_in[16*k +: 16]               = 16'($urandom);
      bus.ch_gain[GAIN_BITS*k +: GAIN_BITS] = (GAIN_BITS)'($urandom);
    end
    bus.ch_mute = (N_CH)'($urandom);
  endtask

  task automatic do_mix(input string name, input bit perturb);
    int er, ec, lat, nv;
    model(er, ec);
    apply();
    bus.pblrc = 1'b1;
    lat = -1;
    nv  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.mix_valid) begin
        nv++;
        if (lat < 0) lat = c;
      end
      if (c == 1 && perturb) scramble();
      if (c == 2) bus.pblrc = 1'b0;
    end
    update_peak(er);
    check({name, ".latency"},   lat, N_CH + 2);
    check({name, ".valid_cnt"}, nv, 1);
    check({name, ".mix_out"},   int'($signed(bus.mix_out)), er);
    check({name, ".clip"},      int'(bus.clip), ec);
    check({name, ".overrun"},   int'(bus.overrun), 0);
    check({name, ".peak"},      int'(bus.peak_out), peak_m);
  endtask

  task automatic do_overrun(input string name, input bit clr_same);
    int er, ec, nv;
    model(er, ec);
    apply();
    bus.pblrc = 1'b1;
    nv = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (bus.mix_valid) nv++;
      if (c == 1) bus.pblrc = 1'b0;
      if (c == 2) begin
        bus.pblrc         = 1'b1;
        bus.clear_overrun = clr_same;
      end
      if (c == 3) begin
        bus.pblrc         = 1'b0;
        bus.clear_overrun = 1'b0;
      end
    end
    check({name, ".valid_cnt"}, nv, 1);
    check({name, ".mix_out"},   int'($signed(bus.mix_out)), er);
    check({name, ".overrun"},   int'(bus.overrun), 1);
    tick(); tick();
    check({name, ".overrun_held"}, int'(bus.overrun), 1);
    bus.clear_overrun = 1'b1;
    tick();
    bus.clear_overrun = 1'b0;
    peak_m = 0;
    check({name, ".overrun_clr"}, int'(bus.overrun), 0);
    tick();
    check({name, ".peak_clr"}, int'(bus.peak_out), peak_m);
  endtask

  initial begin
    int nv;
    bus.pblrc         = 1'b0;
    bus.ch_in         = '0;
    bus.ch_gain       = '0;
    bus.ch_mute       = '0;
    bus.clear_overrun = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst.mix_out",   int'($signed(bus.mix_out)), 0);
    check("rst.mix_valid", int'(bus.mix_valid), 0);
    check("rst.clip",      int'(bus.clip), 0);
    check("rst.overrun",   int'(bus.overrun), 0);
    check("rst.peak",      int'(bus.peak_out), 0);
    rst = 1'b0;
    tick(); tick();

    set_stim(1000, 0, 0, 0, UNITY_GAIN, 0, 0, 0, 4'b0000);
    do_mix("unity", 0);
    set_stim(20000, 20000, 20000, 20000, 128, 128, 128, 128, 4'b0000);
    do_mix("sat_pos", 0);
    set_stim(-32768, -32768, 0, 0, 255, 255, 0, 0, 4'b0000);
    do_mix("sat_neg", 0);
    set_stim(1001, 0, 0, 0, 64, 0, 0, 0, 4'b0000);
    do_mix("half_pos", 0);
    set_stim(-1001, 0, 0, 0, 64, 0, 0, 0, 4'b0000);
    do_mix("half_neg", 0);
    set_stim(10000, 10000, 0, 0, 128, 128, 0, 0, 4'b0010);
    do_mix("mute_snap", 1);
    set_stim(-32768, 32767, -5, 77, 255, 255, 255, 255, 4'b1111);
    do_mix("all_muted", 0);
    set_stim(-32768, 32767, -5, 77, 0, 0, 0, 0, 4'b0000);
    do_mix("zero_gain", 0);

    set_stim(1234, -4321, 555, 9, 100, 200, 30, 255, 4'b0000);
    do_overrun("ovr", 0);
    set_stim(-700, 300, 2000, -9000, 17, 99, 128, 64, 4'b0100);
    do_overrun("ovr_setwins", 1);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < N_CH; k++) begin
        case ($urandom_range(0, 3))
          0:       st_ch[k] = int'($signed(16'($urandom)));
          1:       st_ch[k] = -32768;
          2:       st_ch[k] = 32767;
          default: st_ch[k] = int'($urandom_range(0, 400)) - 200;
        endcase
        st_gain[k] = int'($urandom_range(0, 255));
      end
      st_mute = (N_CH)'($urandom_range(0, 15));
      do_mix($sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
    end

    // Reset while accumulating: outputs drop at once and no valid follows.
    set_stim(5000, 6000, 7000, 8000, 128, 128, 128, 128, 4'b0000);
    apply();
    bus.pblrc = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst.mix_out",   int'($signed(bus.mix_out)), 0);
    check("midrst.mix_valid", int'(bus.mix_valid), 0);
    check("midrst.clip",      int'(bus.clip), 0);
    check("midrst.peak",      int'(bus.peak_out), 0);
    peak_m = 0;
    bus.pblrc = 1'b0;
    #2;
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.mix_valid) nv++;
    end
    check("midrst.no_valid", nv, 0);
    set_stim(-3000, 1500, 250, -125, 128, 128, 128, 128, 4'b0000);
    do_mix("after_rst", 0);

    set_stim(-300, 0, 0, 0, 128, 0, 0, 0, 4'b0000);
    do_mix("peak_a", 0);
    set_stim(200, 0, 0, 0, 128, 0, 0, 0, 4'b0000);
    do_mix("peak_b", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
